// File: rtl/outpkt_join_rr_if.sv
// outpkt_join_rr_if: handshake bundle for the packet joiner.
//   din/pkt_end/wr_en/full : N source write ports; source i owns din[WIDTH*(i+1)-1 : WIDTH*i]
//   dout/dout_pkt_end/dout_src/rd_en/empty : single host-side read port
// master = environment (sources + consumer), slave = joiner.
interface outpkt_join_rr_if #(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 16
);
    localparam int unsigned SRC_W = (N > 1) ? $clog2(N) : 1;

    logic [WIDTH*N-1:0] din;
    logic [N-1:0]       pkt_end;
    logic [N-1:0]       wr_en;
    logic [N-1:0]       full;
    logic [WIDTH-1:0]   dout;
    logic               dout_pkt_end;
    logic [SRC_W-1:0]   dout_src;
    logic               rd_en;
    logic               empty;

    modport master (
        output din, pkt_end, wr_en, rd_en,
        input  full, dout, dout_pkt_end, dout_src, empty
    );

    modport slave (
        input  din, pkt_end, wr_en, rd_en,
        output full, dout, dout_pkt_end, dout_src, empty
    );
endinterface

// File: rtl/outpkt_join_rr.sv
// outpkt_join_rr: packet-atomic N-to-1 joiner with rotating priority and a
// 2-entry output buffer. Once a source is granted, its whole packet passes
// before another source is served.
// Ports:
//   CLK  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - outpkt_join_rr_if.slave (source write ports, host read port)
// Build option: OUTPKT_JOIN_HEADER_EN prefixes every packet with one word
// carrying the source number (zero-extended, pkt_end=0).
module outpkt_join_rr #(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic              CLK,
    input  logic              rst,
    outpkt_join_rr_if.slave   bus
);
    localparam int unsigned SRC_W = (N > 1) ? $clog2(N) : 1;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             pkt_end;
        logic [SRC_W-1:0] src;
    } entry_t;

`ifdef OUTPKT_JOIN_HEADER_EN
    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, PASS = 2'd2} state_t;
`else
    typedef enum logic {IDLE = 1'b0, PASS = 1'b1} state_t;
`endif

    state_t           state;
    logic [SRC_W-1:0] g;
    logic [SRC_W-1:0] ptr;
    logic [SRC_W-1:0] pick;
    logic [SRC_W-1:0] ptr_next;
    logic [1:0]       count;
    entry_t           head;
    entry_t           tail;
    entry_t           push_entry;
    logic [N-1:0]     full_c;
    logic             accept;
    logic             push;
    logic             pop;
    logic             hdr_push;
    logic [WIDTH-1:0] src_word [N];

    // Split the flat input bus into per-source words
    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign src_word[i] = bus.din[WIDTH*i +: WIDTH];
    end

    // Rotating-priority pick: first requester at or after ptr, wrapping
    if (N == 1) begin : g_single
        assign pick     = '0;
        assign ptr_next = '0;
    end else begin : g_rr
        int unsigned idx;
        logic        found;

        always_comb begin
            pick  = ptr;
            found = 1'b0;
            idx   = 0;
            for (int unsigned k = 0; k < N; k++) begin
                idx = 32'(ptr) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (!found && bus.wr_en[SRC_W'(idx)]) begin
                    pick  = SRC_W'(idx);
                    found = 1'b1;
                end
            end
        end

        assign ptr_next = (g == SRC_W'(N - 1)) ? '0 : g + SRC_W'(1);
    end

    // Only the granted source may write, and only while the buffer has room.
    // Depends on registered state/count only, never on rd_en.
    always_comb begin
        full_c = '1;
        if (state == PASS && count != 2'd2) begin
            full_c[g] = 1'b0;
        end
    end

    assign bus.full = full_c;
    assign accept   = (state == PASS) && bus.wr_en[g] && (count != 2'd2);
    assign pop      = bus.rd_en && (count != 2'd0);

`ifdef OUTPKT_JOIN_HEADER_EN
    assign hdr_push = (state == HDR) && (count != 2'd2);
`else
    assign hdr_push = 1'b0;
`endif

    assign push = accept || hdr_push;

    // Buffer write payload: header word or the granted source's word
    always_comb begin
        push_entry.data    = src_word[g];
        push_entry.pkt_end = bus.pkt_end[g];
        push_entry.src     = g;
        if (hdr_push) begin
            push_entry.data    = WIDTH'(g);
            push_entry.pkt_end = 1'b0;
        end
    end

    // Grant FSM
    always_ff @(posedge CLK) begin
        if (rst) begin
            state <= IDLE;
            g     <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.wr_en) begin
                        g <= pick;
`ifdef OUTPKT_JOIN_HEADER_EN
                        state <= HDR;
`else
                        state <= PASS;
`endif
                    end
                end
`ifdef OUTPKT_JOIN_HEADER_EN
                HDR: begin
                    if (count != 2'd2) begin
                        state <= PASS;
                    end
                end
`endif
                PASS: begin
                    if (accept && bus.pkt_end[g]) begin
                        state <= IDLE;
                        ptr   <= ptr_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // 2-entry output buffer; head is a register so dout is registered
    always_ff @(posedge CLK) begin
        if (rst) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head <= push_entry;
                    end else begin
                        tail <= push_entry;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // count is 1 here: full blocks a push while count is 2
                    if (count == 2'd1) begin
                        head <= push_entry;
                    end else begin
                        head <= tail;
                        tail <= push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.dout         = head.data;
    assign bus.dout_pkt_end = head.pkt_end;
    assign bus.dout_src     = head.src;
    assign bus.empty        = (count == 2'd0);
endmodule
